// File: rtl/scurve_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : scurve_stream_pkg
// Purpose : Shared constants for the S-curve result stream: framing words,
//           channel-word high bytes, DAC nibble, record mode encodings,
//           violation codes and parser state encodings.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package scurve_stream_pkg;

   // Framing words
   localparam logic [15:0] c_word_hdr    = 16'h5343;
   localparam logic [15:0] c_word_tail   = 16'hFF45;
   localparam logic [15:0] c_word_unmask = 16'h43FF;

   // Channel-word high bytes and DAC-word nibble
   localparam logic [7:0]  c_chn_single  = 8'h43;
   localparam logic [7:0]  c_chn_scan    = 8'h63;
   localparam logic [3:0]  c_dac_nibble  = 4'hD;

   // Record mode encodings
   localparam logic [1:0]  c_mode_single = 2'd0;
   localparam logic [1:0]  c_mode_scan   = 2'd1;
   localparam logic [1:0]  c_mode_unmask = 2'd2;

   // Violation codes
   localparam logic [2:0]  c_err_none    = 3'd0;
   localparam logic [2:0]  c_err_chn     = 3'd1;
   localparam logic [2:0]  c_err_dac     = 3'd2;
   localparam logic [2:0]  c_err_hdr     = 3'd3;
   localparam logic [2:0]  c_err_next    = 3'd4;
   localparam logic [2:0]  c_err_step    = 3'd5;

   // Parser states
   localparam logic [2:0]  c_st_hunt     = 3'd0;
   localparam logic [2:0]  c_st_exp_chn  = 3'd1;
   localparam logic [2:0]  c_st_exp_dac  = 3'd2;
   localparam logic [2:0]  c_st_trig     = 3'd3;
   localparam logic [2:0]  c_st_emit     = 3'd4;
   localparam logic [2:0]  c_st_next     = 3'd5;

endpackage
`default_nettype wire

// File: rtl/scurve_word_classifier.sv
`default_nettype none
// ============================================================================
// Module  : scurve_word_classifier
// Purpose : Purely combinational decode of one 16-bit stream word into its
//           word class and the fields carried by channel and DAC words.
// Ports   : word    - stream word under inspection
//           is_hdr  - word is the frame header
//           is_tail - word is the frame tail
//           is_chn  - word is a channel word (0x43xx/0x63xx, bits[7:6]=00,
//                     or the unmask-all word 0x43FF)
//           is_dac  - word is a DAC word (0xD nibble, bits[11:10]=00)
//           mode    - record mode implied by a channel word
//           chn     - channel number carried by a channel word
//           dac     - DAC code carried by a DAC word
// Rev     : 1.0  initial release
// ============================================================================
module scurve_word_classifier
   import scurve_stream_pkg::*;
(
   input  logic [15:0] word,
   output logic        is_hdr,
   output logic        is_tail,
   output logic        is_chn,
   output logic        is_dac,
   output logic [1:0]  mode,
   output logic [5:0]  chn,
   output logic [9:0]  dac
);

   logic w_unmask;
   logic w_hi_ok;

   assign w_unmask = (word == c_word_unmask);
   assign w_hi_ok  = (word[15:8] == c_chn_single) || (word[15:8] == c_chn_scan);

   assign is_hdr   = (word == c_word_hdr);
   assign is_tail  = (word == c_word_tail);
   assign is_chn   = w_unmask || (w_hi_ok && (word[7:6] == 2'b00));
   assign is_dac   = (word[15:12] == c_dac_nibble) && (word[11:10] == 2'b00);
   assign dac      = word[9:0];

   // The unmask-all word addresses every channel, so no channel number applies.
   assign chn      = w_unmask ? 6'd0 : word[5:0];

   always_comb begin
      mode = c_mode_single;
      if (w_unmask) begin
         mode = c_mode_unmask;
      end else if (word[15:8] == c_chn_scan) begin
         mode = c_mode_scan;
      end
   end

endmodule
`default_nettype wire

// File: rtl/scurve_stream_parser.sv
`default_nettype none
// ============================================================================
// Module  : scurve_stream_parser
// Purpose : Pops the S-curve result stream from an FWFT FIFO, checks the
//           framing (header, channel, DAC, trigger words, tail) and emits one
//           decoded record per DAC step over a valid/ready handshake.
//           Violations pulse err_pulse and leave a sticky err_code; parsing
//           resynchronises on the next header.
// Config  : SCURVE_PARSER_DAC_CHECK_EN - when defined, each DAC word after the
//           first in a channel must equal previous + cfg_dac_interval
//           (10-bit wrap), otherwise error 5 is flagged (record still sent).
// Ports   : Clk, reset (sync, active-high)
//           in_empty/in_dout/in_rd_en      - FWFT source FIFO
//           cfg_dac_interval               - expected DAC step
//           rec_valid/rec_ready            - record handshake
//           rec_mode/rec_chn/rec_dac/rec_trig - record fields
//           frame_active/frame_done/rec_cnt   - frame status
//           err_pulse/err_code             - violation reporting
// Rev     : 1.0  initial release
// ============================================================================
module scurve_stream_parser
   import scurve_stream_pkg::*;
#(
   parameter int TRIG_WORDS = 2
)
(
   input  logic                    Clk,
   input  logic                    reset,
   input  logic                    in_empty,
   input  logic [15:0]             in_dout,
   output logic                    in_rd_en,
   input  logic [9:0]              cfg_dac_interval,
   output logic                    rec_valid,
   input  logic                    rec_ready,
   output logic [1:0]              rec_mode,
   output logic [5:0]              rec_chn,
   output logic [9:0]              rec_dac,
   output logic [16*TRIG_WORDS-1:0] rec_trig,
   output logic                    frame_active,
   output logic                    frame_done,
   output logic [16:0]             rec_cnt,
   output logic                    err_pulse,
   output logic [2:0]              err_code
);

   localparam int c_trig_w = 16 * TRIG_WORDS;
   localparam int c_idx_w  = (TRIG_WORDS > 1) ? $clog2(TRIG_WORDS) : 1;
   localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(TRIG_WORDS - 1);

   logic [2:0]          r_state;
   logic [c_idx_w-1:0]  r_idx;
   logic                w_pop;
   logic                w_is_hdr;
   logic                w_is_tail;
   logic                w_is_chn;
   logic                w_is_dac;
   logic [1:0]          w_mode;
   logic [5:0]          w_chn;
   logic [9:0]          w_dac;
   logic [c_trig_w-1:0] w_trig_next;
   logic                w_step_err;

   scurve_word_classifier u_classifier (
      .word    (in_dout),
      .is_hdr  (w_is_hdr),
      .is_tail (w_is_tail),
      .is_chn  (w_is_chn),
      .is_dac  (w_is_dac),
      .mode    (w_mode),
      .chn     (w_chn),
      .dac     (w_dac)
   );

   // No pops while a record waits for the consumer.
   assign in_rd_en  = !reset && !in_empty && (r_state != c_st_emit);
   assign w_pop     = in_rd_en;
   assign rec_valid = (r_state == c_st_emit);

   // Trigger words shift in from the LSB end so the first word ends in the MSBs.
   generate
      if (TRIG_WORDS == 1) begin : g_trig_single
         assign w_trig_next = in_dout;
      end else begin : g_trig_shift
         assign w_trig_next = {rec_trig[c_trig_w-17:0], in_dout};
      end
   endgenerate

`ifdef SCURVE_PARSER_DAC_CHECK_EN
   logic [9:0] w_dac_expect;
   assign w_dac_expect = rec_dac + cfg_dac_interval;
   // Only consulted in NEXT, where rec_dac always holds this channel's prior step.
   assign w_step_err   = (w_dac != w_dac_expect);
`else
   logic unused_cfg;
   assign unused_cfg = ^cfg_dac_interval;
   assign w_step_err = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state      <= c_st_hunt;
         r_idx        <= '0;
         rec_mode     <= '0;
         rec_chn      <= '0;
         rec_dac      <= '0;
         rec_trig     <= '0;
         frame_active <= 1'b0;
         frame_done   <= 1'b0;
         rec_cnt      <= '0;
         err_pulse    <= 1'b0;
         err_code     <= c_err_none;
      end else begin
         err_pulse  <= 1'b0;
         frame_done <= 1'b0;
         case (r_state)
            c_st_hunt: begin
               if (w_pop && w_is_hdr) begin
                  r_state      <= c_st_exp_chn;
                  frame_active <= 1'b1;
                  rec_cnt      <= '0;
                  err_code     <= c_err_none;
               end
            end
            c_st_exp_chn: begin
               if (w_pop) begin
                  if (w_is_hdr) begin
                     err_pulse <= 1'b1;
                     err_code  <= c_err_hdr;
                     rec_cnt   <= '0;
                  end else if (w_is_chn) begin
                     rec_mode <= w_mode;
                     rec_chn  <= w_chn;
                     r_state  <= c_st_exp_dac;
                  end else begin
                     err_pulse    <= 1'b1;
                     err_code     <= c_err_chn;
                     frame_active <= 1'b0;
                     r_state      <= c_st_hunt;
                  end
               end
            end
            c_st_exp_dac: begin
               if (w_pop) begin
                  if (w_is_hdr) begin
                     err_pulse <= 1'b1;
                     err_code  <= c_err_hdr;
                     rec_cnt   <= '0;
                     r_state   <= c_st_exp_chn;
                  end else if (w_is_dac) begin
                     rec_dac <= w_dac;
                     r_idx   <= '0;
                     r_state <= c_st_trig;
                  end else begin
                     err_pulse    <= 1'b1;
                     err_code     <= c_err_dac;
                     frame_active <= 1'b0;
                     r_state      <= c_st_hunt;
                  end
               end
            end
            c_st_trig: begin
               // Every word here is payload, including one that looks like a header.
               if (w_pop) begin
                  rec_trig <= w_trig_next;
                  if (r_idx == c_idx_last) begin
                     r_state <= c_st_emit;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            c_st_emit: begin
               if (rec_ready) begin
                  if (rec_cnt != 17'h1FFFF) begin
                     rec_cnt <= rec_cnt + 1'b1;
                  end
                  r_state <= c_st_next;
               end
            end
            c_st_next: begin
               if (w_pop) begin
                  if (w_is_dac) begin
                     if (w_step_err) begin
                        err_pulse <= 1'b1;
                        err_code  <= c_err_step;
                     end
                     rec_dac <= w_dac;
                     r_idx   <= '0;
                     r_state <= c_st_trig;
                  end else if (w_is_chn) begin
                     rec_mode <= w_mode;
                     rec_chn  <= w_chn;
                     r_state  <= c_st_exp_dac;
                  end else if (w_is_tail) begin
                     frame_done   <= 1'b1;
                     frame_active <= 1'b0;
                     r_state      <= c_st_hunt;
                  end else if (w_is_hdr) begin
                     err_pulse <= 1'b1;
                     err_code  <= c_err_hdr;
                     rec_cnt   <= '0;
                     r_state   <= c_st_exp_chn;
                  end else begin
                     err_pulse    <= 1'b1;
                     err_code     <= c_err_next;
                     frame_active <= 1'b0;
                     r_state      <= c_st_hunt;
                  end
               end
            end
            default: begin
               r_state <= c_st_hunt;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
